// File: rtl/othello_ctrl.sv
// othello_ctrl: control sequencer for the Othello board datapath.
//
// Turns debounced button levels into single-cycle datapath strobes. It also
// scans a BOX_SIZE x BOX_SIZE pixel window for each cell redraw, blocks moves
// that would leave the board and placements on occupied cells, and opens a
// win-detect window after every placement.
//
// Ports:
//   clock, resetn             clock; synchronous reset, active-high
//   key_up/down/left/right    debounced direction buttons, 1 = pressed
//   key_place                 debounced place button, 1 = pressed
//   x, y                      current cursor cell from the datapath
//   cell_occupied             cell (x,y) already holds a disk
//   winsignal                 datapath win flag, sampled at end of DETECT
//   move_up/down/left/right   one-cycle cursor move strobes
//   plot_empty, plot_box      one-cycle plot-coordinate load strobes
//   place_disk, turn_side     one-cycle disk placement / side toggle strobes
//   detect_en                 win-detect window (DETECT_CYCLES cycles)
//   plot, dx, dy              VGA write enable and pixel offset in the box
//   busy                      high in every state except IDLE and WIN
//   game_over                 high in WIN
module othello_ctrl #(
    parameter int BOX_SIZE      = 13,
    parameter int DETECT_CYCLES = 8,
    parameter int BOARD_MAX     = 7
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_place,
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic       cell_occupied,
    input  logic       winsignal,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic       plot_empty,
    output logic       plot_box,
    output logic       place_disk,
    output logic       turn_side,
    output logic       detect_en,
    output logic       plot,
    output logic [3:0] dx,
    output logic [3:0] dy,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_MOVE_LEFT, S_MOVE_RIGHT,
        S_ERASE_LD, S_ERASE_DRAW, S_BOX_LD, S_BOX_DRAW, S_PLACE_LD,
        S_PLACE_DRAW, S_DETECT, S_TURN, S_RELEASE, S_WIN
    } state_t;

    localparam logic [3:0] PIX_LAST  = 4'(BOX_SIZE - 1);
    localparam logic [2:0] COORD_MAX = 3'(BOARD_MAX);
    localparam int         DET_W     = (DETECT_CYCLES > 1) ? $clog2(DETECT_CYCLES) : 1;
    localparam logic [DET_W-1:0] DET_LAST = DET_W'(DETECT_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_dx;
    logic [3:0]       r_dy;
    logic [DET_W-1:0] r_det_cnt;

    logic w_in_draw;
    logic w_draw_last;
    logic w_det_last;
    logic w_any_key;

    assign w_in_draw   = (r_state == S_ERASE_DRAW) || (r_state == S_BOX_DRAW) ||
                         (r_state == S_PLACE_DRAW);
    assign w_draw_last = (r_dx == PIX_LAST) && (r_dy == PIX_LAST);
    assign w_det_last  = (r_det_cnt == DET_LAST);
    assign w_any_key   = key_up | key_down | key_left | key_right | key_place;

    // State register plus the pixel and detect counters. The counters are
    // zero on entry to every draw/detect state and clear themselves on exit,
    // so dx/dy read 0 everywhere outside the draw states.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_state   <= S_INIT;
            r_dx      <= '0;
            r_dy      <= '0;
            r_det_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_in_draw) begin
                if (r_dx == PIX_LAST) begin
                    r_dx <= '0;
                    r_dy <= w_draw_last ? 4'd0 : r_dy + 4'd1;
                end else begin
                    r_dx <= r_dx + 4'd1;
                end
            end
            if (r_state == S_DETECT) begin
                r_det_cnt <= w_det_last ? '0 : r_det_cnt + 1'b1;
            end
        end
    end

    // Next-state logic. The highest-priority pressed key alone decides the
    // action; an illegal request parks in RELEASE without trying lower keys.
    // NOTE: default assignment first so no path leaves w_next_state unassigned
    // (which would infer a latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_INIT:       w_next_state = S_BOX_LD;
            S_IDLE: begin
                if (key_place)
                    w_next_state = cell_occupied ? S_RELEASE : S_PLACE_LD;
                else if (key_up)
                    w_next_state = (y != 3'd0) ? S_MOVE_UP : S_RELEASE;
                else if (key_down)
                    w_next_state = (y != COORD_MAX) ? S_MOVE_DOWN : S_RELEASE;
                else if (key_left)
                    w_next_state = (x != 3'd0) ? S_MOVE_LEFT : S_RELEASE;
                else if (key_right)
                    w_next_state = (x != COORD_MAX) ? S_MOVE_RIGHT : S_RELEASE;
            end
            S_MOVE_UP, S_MOVE_DOWN,
            S_MOVE_LEFT, S_MOVE_RIGHT: w_next_state = S_ERASE_LD;
            S_ERASE_LD:   w_next_state = S_ERASE_DRAW;
            S_ERASE_DRAW: if (w_draw_last) w_next_state = S_BOX_LD;
            S_BOX_LD:     w_next_state = S_BOX_DRAW;
            S_BOX_DRAW:   if (w_draw_last) w_next_state = S_RELEASE;
            S_PLACE_LD:   w_next_state = S_PLACE_DRAW;
            S_PLACE_DRAW: if (w_draw_last) w_next_state = S_DETECT;
            S_DETECT:     if (w_det_last) w_next_state = winsignal ? S_WIN : S_TURN;
            S_TURN:       w_next_state = S_RELEASE;
            S_RELEASE:    if (!w_any_key) w_next_state = S_IDLE;
            S_WIN:        w_next_state = S_WIN;
            default:      w_next_state = S_INIT;
        endcase
    end

    // Output decode: pure function of the registered state, so each strobe
    // is high for exactly the one cycle its state lasts.
    always_comb begin
        move_up    = 1'b0;
        move_down  = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;
        plot_empty = 1'b0;
        plot_box   = 1'b0;
        place_disk = 1'b0;
        turn_side  = 1'b0;
        detect_en  = 1'b0;
        plot       = w_in_draw;
        busy       = (r_state != S_IDLE) && (r_state != S_WIN);
        game_over  = (r_state == S_WIN);
        case (r_state)
            S_MOVE_UP:    move_up    = 1'b1;
            S_MOVE_DOWN:  move_down  = 1'b1;
            S_MOVE_LEFT:  move_left  = 1'b1;
            S_MOVE_RIGHT: move_right = 1'b1;
            S_ERASE_LD:   plot_empty = 1'b1;
            S_BOX_LD:     plot_box   = 1'b1;
            S_PLACE_LD:   place_disk = 1'b1;
            S_DETECT:     detect_en  = 1'b1;
            S_TURN:       turn_side  = 1'b1;
            default:      ;
        endcase
    end

    assign dx = r_dx;
    assign dy = r_dy;

endmodule
